// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - HH:MM alarm store, digit editor and ring/snooze sequencer
// Optional feature macro: ALARM_SNOOZE_EN (SNOOZE state, snooze counter, snooze input)
module alarm_scheduler #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 540
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] secU,
  input  logic [3:0] secT,
  input  logic [3:0] minU,
  input  logic [3:0] minT,
  input  logic [3:0] hrU,
  input  logic [3:0] hrT,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic       switch_select,
  input  logic       increment,
  input  logic       snooze,
  input  logic       dismiss,
  output logic [3:0] alarm_minU,
  output logic [3:0] alarm_minT,
  output logic [3:0] alarm_hrU,
  output logic [3:0] alarm_hrT,
  output logic [3:0] sel,
  output logic       editing,
  output logic       ring,
  output logic       snoozing
);

  localparam int RCW = $clog2(RING_SECONDS + 1);

  typedef enum logic [1:0] {MONITOR, SET, RINGING, SNOOZE} state_e;

  state_e         state_q;
  logic [3:0]     min_u_q, min_t_q, hr_u_q, hr_t_q, sel_q;
  logic [3:0]     min_u_d, min_t_d, hr_u_d, hr_t_d;
  logic           match_d, match_q, trigger;
  logic [RCW-1:0] ring_cnt_q, ring_cnt_d;

  // Seconds must be :00 so the alarm only fires at the top of the minute
  assign match_d = (hrT == hr_t_q) && (hrU == hr_u_q) && (minT == min_t_q) &&
                   (minU == min_u_q) && (secT == 4'd0) && (secU == 4'd0);
  // Rising edge only: a dismissed alarm stays quiet for the rest of the matching second
  assign trigger = alarm_en & match_d & ~match_q;
  assign ring_cnt_d = (ring_cnt_q == RCW'(RING_SECONDS)) ? ring_cnt_q : ring_cnt_q + RCW'(1);

`ifdef ALARM_SNOOZE_EN
  localparam int SCW = $clog2(SNOOZE_SECONDS + 1);
  logic [SCW-1:0] snz_cnt_q, snz_cnt_d;
  assign snz_cnt_d = (snz_cnt_q == SCW'(SNOOZE_SECONDS)) ? snz_cnt_q : snz_cnt_q + SCW'(1);
  assign snoozing  = (state_q == SNOOZE);
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snoozing      = 1'b0;
`endif

  assign alarm_minU = min_u_q;
  assign alarm_minT = min_t_q;
  assign alarm_hrU  = hr_u_q;
  assign alarm_hrT  = hr_t_q;
  assign sel        = sel_q;
  assign editing    = (state_q == SET);
  assign ring       = (state_q == RINGING);

  // Incremented value of the selected digit; hours are kept within 00..23
  always_comb begin
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    hr_u_d  = hr_u_q;
    hr_t_d  = hr_t_q;
    if (sel_q[0]) min_u_d = (min_u_q >= 4'd9) ? 4'd0 : min_u_q + 4'd1;
    if (sel_q[1]) min_t_d = (min_t_q >= 4'd5) ? 4'd0 : min_t_q + 4'd1;
    if (sel_q[2]) begin
      if (hr_t_q == 4'd2) hr_u_d = (hr_u_q >= 4'd3) ? 4'd0 : hr_u_q + 4'd1;
      else                hr_u_d = (hr_u_q >= 4'd9) ? 4'd0 : hr_u_q + 4'd1;
    end
    if (sel_q[3]) begin
      hr_t_d = (hr_t_q >= 4'd2) ? 4'd0 : hr_t_q + 4'd1;
      if (hr_t_d == 4'd2 && hr_u_q > 4'd3) hr_u_d = 4'd0;
    end
  end

  // Mode sequencer with alarm digit store, edit cursor and ring/snooze counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MONITOR;
      min_u_q    <= 4'd0;
      min_t_q    <= 4'd0;
      hr_u_q     <= 4'd0;
      hr_t_q     <= 4'd0;
      sel_q      <= 4'd0;
      match_q    <= 1'b0;
      ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      match_q <= match_d;
      case (state_q)
        MONITOR: begin
          if (set_alarm) begin
            state_q <= SET;
            sel_q   <= 4'b0001;
          end else if (trigger) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
          end
        end
        SET: begin
          if (!set_alarm) begin
            state_q <= MONITOR;
            sel_q   <= 4'd0;
            // Leaving edit on the current minute must not fire right away
            match_q <= 1'b1;
          end else begin
            if (increment) begin
              min_u_q <= min_u_d;
              min_t_q <= min_t_d;
              hr_u_q  <= hr_u_d;
              hr_t_q  <= hr_t_d;
            end
            if (switch_select) sel_q <= {sel_q[2:0], sel_q[3]};
          end
        end
        RINGING: begin
          if (!alarm_en || dismiss) begin
            state_q <= MONITOR;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze) begin
            state_q   <= SNOOZE;
            snz_cnt_q <= '0;
`endif
          end else if (tick) begin
            ring_cnt_q <= ring_cnt_d;
            if (ring_cnt_d == RCW'(RING_SECONDS)) state_q <= MONITOR;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (!alarm_en || dismiss) begin
            state_q <= MONITOR;
          end else if (tick) begin
            snz_cnt_q <= snz_cnt_d;
            if (snz_cnt_d == SCW'(SNOOZE_SECONDS)) begin
              state_q    <= RINGING;
              ring_cnt_q <= '0;
            end
          end
        end
`endif
        default: state_q <= MONITOR;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - randomized and directed bench for alarm_scheduler against a time-of-day model
module tb_alarm_scheduler;

  localparam int RING_S = 5;
  localparam int SNZ_S  = 3;

  localparam int M_MON  = 0;
  localparam int M_SET  = 1;
  localparam int M_RING = 2;
  localparam int M_SNZ  = 3;

  localparam int P_SW  = 0;
  localparam int P_INC = 1;
  localparam int P_SNZ = 2;
  localparam int P_DIS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, tick, alarm_en, set_alarm, switch_select, increment, snooze, dismiss;
  logic [3:0] secU, secT, minU, minT, hrU, hrT;
  logic [3:0] alarm_minU, alarm_minT, alarm_hrU, alarm_hrT, sel;
  logic       editing, ring, snoozing;

  int time_s;

  assign secU = 4'(time_s % 10);
  assign secT = 4'((time_s / 10) % 6);
  assign minU = 4'((time_s / 60) % 10);
  assign minT = 4'((time_s / 600) % 6);
  assign hrU  = 4'((time_s / 3600) % 10);
  assign hrT  = 4'(time_s / 36000);

  alarm_scheduler #(.RING_SECONDS(RING_S), .SNOOZE_SECONDS(SNZ_S)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .secU(secU), .secT(secT), .minU(minU), .minT(minT), .hrU(hrU), .hrT(hrT),
    .alarm_en(alarm_en), .set_alarm(set_alarm), .switch_select(switch_select),
    .increment(increment), .snooze(snooze), .dismiss(dismiss),
    .alarm_minU(alarm_minU), .alarm_minT(alarm_minT), .alarm_hrU(alarm_hrU), .alarm_hrT(alarm_hrT),
    .sel(sel), .editing(editing), .ring(ring), .snoozing(snoozing)
  );

  // Reference model: digit index 0=minU 1=minT 2=hrU 3=hrT
  int m_mode, m_sel, m_rc, m_sc;
  int m_dig[4];
  bit m_mq;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int alarm_minute();
    return (m_dig[3] * 10 + m_dig[2]) * 60 + m_dig[1] * 10 + m_dig[0];
  endfunction

  task automatic bump(input int k);
    case (k)
      0: m_dig[0] = (m_dig[0] + 1) % 10;
      1: m_dig[1] = (m_dig[1] + 1) % 6;
      2: m_dig[2] = (m_dig[2] + 1) % ((m_dig[3] == 2) ? 4 : 10);
      default: begin
        m_dig[3] = (m_dig[3] + 1) % 3;
        if (m_dig[3] == 2 && m_dig[2] > 3) m_dig[2] = 0;
      end
    endcase
  endtask

  task automatic model_step();
    bit m, mq_next;
    m = (time_s % 60 == 0) && (time_s / 60 == alarm_minute());
    mq_next = m;
    if (reset) begin
      m_mode = M_MON; m_sel = 0; m_rc = 0; m_sc = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      mq_next = 1'b0;
    end else begin
      case (m_mode)
        M_MON: begin
          if (set_alarm) begin m_mode = M_SET; m_sel = 0; end
          else if (alarm_en && m && !m_mq) begin m_mode = M_RING; m_rc = 0; end
        end
        M_SET: begin
          if (!set_alarm) begin m_mode = M_MON; mq_next = 1'b1; end
          else begin
            if (increment) bump(m_sel);
            if (switch_select) m_sel = (m_sel + 1) % 4;
          end
        end
        M_RING: begin
          if (!alarm_en || dismiss) m_mode = M_MON;
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin m_mode = M_SNZ; m_sc = 0; end
`endif
          else if (tick) begin
            m_rc++;
            if (m_rc >= RING_S) m_mode = M_MON;
          end
        end
        default: begin
          if (!alarm_en || dismiss) m_mode = M_MON;
          else if (tick) begin
            m_sc++;
            if (m_sc >= SNZ_S) begin m_mode = M_RING; m_rc = 0; end
          end
        end
      endcase
    end
    m_mq = mq_next;
  endtask

  task automatic check_all();
    logic [15:0] exp_alarm;
    exp_alarm = {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
    check_eq("alarm", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, exp_alarm);
    check_eq("sel", {12'd0, sel}, (m_mode == M_SET) ? 16'(1 << m_sel) : 16'h0);
    check_eq("editing", {15'd0, editing}, 16'(m_mode == M_SET));
    check_eq("ring", {15'd0, ring}, 16'(m_mode == M_RING));
    check_eq("snoozing", {15'd0, snoozing}, 16'(m_mode == M_SNZ));
  endtask

  // Inputs are already driven; advance one edge and compare at the following negedge
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_pulses();
    switch_select = 1'b0; increment = 1'b0; snooze = 1'b0; dismiss = 1'b0; tick = 1'b0;
  endtask

  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        P_SW:    switch_select = 1'b1;
        P_INC:   increment = 1'b1;
        P_SNZ:   snooze = 1'b1;
        default: dismiss = 1'b1;
      endcase
      cycle();
      clear_pulses();
      cycle();
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    time_s = (time_s + 1) % 86400;
    cycle();
  endtask

  task automatic set_alarm_to(input int h, input int mn);
    int t[4];
    int cur;
    t[0] = mn % 10; t[1] = mn / 10; t[2] = h % 10; t[3] = h / 10;
    set_alarm = 1'b1;
    cycle();
    cur = 0;
    for (int k = 3; k >= 0; k--) begin
      while (cur != k) begin
        switch_select = 1'b1; cycle(); switch_select = 1'b0;
        cur = (cur + 1) % 4;
      end
      for (int n = 0; n < 12 && m_dig[k] != t[k]; n++) begin
        increment = 1'b1; cycle(); increment = 1'b0;
      end
    end
    set_alarm = 1'b0;
    cycle();
  endtask

  task automatic make_ring();
    time_s = 7 * 3600 + 29 * 60 + 59;
    cycle();
    do_tick();
  endtask

  initial begin
    reset = 1'b1; alarm_en = 1'b0; set_alarm = 1'b0;
    clear_pulses();
    time_s = 5 * 3600 + 17;
    m_mode = M_MON; m_sel = 0; m_rc = 0; m_sc = 0; m_mq = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    @(negedge clk);

    // Reset with every input active
    tick = 1'b1; alarm_en = 1'b1; set_alarm = 1'b1; switch_select = 1'b1;
    increment = 1'b1; snooze = 1'b1; dismiss = 1'b1;
    cycle();
    cycle();
    check_eq("rst_alarm", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h0000);
    check_eq("rst_sel", {12'd0, sel}, 16'h0);
    check_eq("rst_flags", {13'd0, ring, editing, snoozing}, 16'h0);
    reset = 1'b0; alarm_en = 1'b0; set_alarm = 1'b0;
    clear_pulses();
    cycle();

    // Digit editing and wrap rules
    set_alarm = 1'b1;
    cycle();
    press(P_INC, 3); press(P_SW, 3); press(P_INC, 2); press(P_SW, 3); press(P_INC, 5);
    set_alarm = 1'b0;
    cycle();
    check_eq("edit_2103", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h2103);
    set_alarm = 1'b1;
    cycle();
    press(P_SW, 2); press(P_INC, 1);
    check_eq("edit_2203", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h2203);
    press(P_INC, 2);
    check_eq("hru_wrap3", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h2003);
    press(P_SW, 1); press(P_INC, 1);
    check_eq("hrt_wrap2", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h0003);
    press(P_SW, 3); press(P_INC, 5); press(P_SW, 1); press(P_INC, 1);
    check_eq("edit_1503", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h1503);
    press(P_INC, 1);
    check_eq("hru_force", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h2003);
    switch_select = 1'b1; increment = 1'b1;
    cycle();
    clear_pulses();
    cycle();
    check_eq("inc_then_rot", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h0003);
    check_eq("rot_sel", {12'd0, sel}, 16'h0001);
    set_alarm = 1'b0;
    cycle();
    check_eq("exit_sel", {12'd0, sel}, 16'h0);

    // Ring on match and auto-stop
    set_alarm_to(7, 30);
    check_eq("alarm_0730", {alarm_hrT, alarm_hrU, alarm_minT, alarm_minU}, 16'h0730);
    alarm_en = 1'b1;
    time_s = 7 * 3600 + 29 * 60 + 59;
    cycle(); cycle();
    check_eq("pre_ring", {15'd0, ring}, 16'h0);
    do_tick();
    check_eq("ring_rise", {15'd0, ring}, 16'h1);
    for (int i = 0; i < RING_S - 1; i++) do_tick();
    check_eq("ring_hold", {15'd0, ring}, 16'h1);
    do_tick();
    check_eq("auto_stop", {15'd0, ring}, 16'h0);
    for (int i = 0; i < 3; i++) do_tick();
    check_eq("no_refire", {15'd0, ring}, 16'h0);

    // Snooze / dismiss behaviour
`ifdef ALARM_SNOOZE_EN
    make_ring();
    press(P_SNZ, 1);
    check_eq("snz_enter", {14'd0, ring, snoozing}, 16'h1);
    for (int i = 0; i < SNZ_S - 1; i++) do_tick();
    check_eq("snz_hold", {14'd0, ring, snoozing}, 16'h1);
    do_tick();
    check_eq("rering", {14'd0, ring, snoozing}, 16'h2);
    press(P_DIS, 1);
    check_eq("dismiss", {14'd0, ring, snoozing}, 16'h0);
    make_ring();
    snooze = 1'b1; dismiss = 1'b1;
    cycle();
    clear_pulses();
    cycle();
    check_eq("dis_over_snz", {14'd0, ring, snoozing}, 16'h0);
    make_ring();
    press(P_SNZ, 1);
    alarm_en = 1'b0;
    cycle();
    check_eq("en_drop_snz", {14'd0, ring, snoozing}, 16'h0);
    alarm_en = 1'b1;
    cycle();
`else
    make_ring();
    press(P_SNZ, 1);
    check_eq("snz_ignored", {14'd0, ring, snoozing}, 16'h2);
    press(P_DIS, 1);
    check_eq("dismiss", {14'd0, ring, snoozing}, 16'h0);
`endif

    // Setting the alarm to the current minute must not fire on exit
    time_s = 12 * 3600 + 34 * 60;
    set_alarm_to(12, 34);
    cycle(); cycle(); cycle();
    check_eq("same_min", {15'd0, ring}, 16'h0);

    // Randomized traffic with the time parked near the alarm
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom % 300 == 0);
      if ($urandom % 40 == 0) set_alarm = ~set_alarm;
      alarm_en      = ($urandom % 100 != 0);
      switch_select = ($urandom % 8 == 0);
      increment     = ($urandom % 6 == 0);
      snooze        = ($urandom % 12 == 0);
      dismiss       = ($urandom % 20 == 0);
      tick          = ($urandom % 3 == 0);
      if ($urandom % 40 == 0)
        time_s = (alarm_minute() * 60 - int'($urandom_range(0, 2)) + 86400) % 86400;
      cycle();
      if (tick) time_s = (time_s + 1) % 86400;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
